// File: rtl/tt_um_example.sv
// Serial pattern detector.
// Shifts one bit per enabled cycle into an 8-bit history and compares the newest
// seq_len bits (clamped to 8) against the low bits of a right-aligned pattern.
// It reports a one-cycle match pulse, a sticky detected flag and a saturating
// 6-bit match count.
module tt_um_example (
  input  logic       clk,
  input  logic       rst_n,   // active-high synchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] shift_q, shift_d;
  logic [3:0] fill_q, fill_d;
  logic       pulse_q;
  logic       sticky_q;
  logic [5:0] count_q;

  logic [3:0] len;
  logic [7:0] mask;
  logic       match;

  // ui_in[7:6] carry no function
  logic unused_bits;
  assign unused_bits = ^ui_in[7:6];

  // Next history and fill level as if the current bit is accepted
  always_comb begin
    shift_d = {shift_q[6:0], ui_in[0]};
    fill_d  = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
  end

  // Effective length and compare mask; len 0 yields an empty mask
  always_comb begin
    len  = (ui_in[5:1] > 5'd8) ? 4'd8 : ui_in[4:1];
    mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (4'(i) < len);
    end
  end

  // Match needs a non-zero length, enough history, and equal masked bits
  always_comb begin
    match = (len != 4'd0) && (fill_d >= len) && (((shift_d ^ uio_in) & mask) == 8'h00);
  end

  // State update: reset wins over enable; disabled cycles hold all but the pulse
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shift_q  <= 8'h00;
      fill_q   <= 4'd0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= 6'd0;
    end else if (ena) begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      pulse_q <= match;
      if (match) begin
        sticky_q <= 1'b1;
        if (count_q != 6'd63) begin
          count_q <= count_q + 6'd1;
        end
      end
    end else begin
      pulse_q <= 1'b0;
    end
  end

  // Outputs come straight from registers; the bidirectional pins stay inputs
  always_comb begin
    uo_out  = {count_q, sticky_q, pulse_q};
    uio_out = 8'h00;
    uio_oe  = 8'h00;
  end

endmodule

// File: tb/tb_tt_um_example.sv
// Directed and random stimulus against a behavioural reference of the detector.
// Expected outputs are queued when stimulus is applied and popped after the edge.
module tb_tt_um_example;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];

  // Reference state: received bits (oldest first), match count, sticky flag
  bit hist[$];
  int m_cnt;
  bit m_sticky;

  tt_um_example dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: walk the newest bits against the pattern one by one
  task automatic model_accept(input bit b, input int unsigned len_raw, input logic [7:0] pat,
                              output logic [7:0] expv);
    int  len;
    bit  m;
    len = (len_raw > 8) ? 8 : int'(len_raw);
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());
    m = (len > 0) && (hist.size() >= len);
    for (int i = 0; i < len; i++) begin
      if (m && hist[hist.size() - 1 - i] != pat[i]) m = 1'b0;
    end
    if (m) begin
      m_sticky = 1'b1;
      if (m_cnt < 63) m_cnt++;
    end
    expv = {6'(m_cnt), m_sticky, m};
  endtask

  task automatic pop_and_check(input string tag);
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed %h expected scoreboard entry (queue empty)", tag, uo_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, uo_out, e);
    end
    check({tag, "_uio_out"}, uio_out, 8'h00);
    check({tag, "_uio_oe"}, uio_oe, 8'h00);
  endtask

  task automatic step(input bit b, input int unsigned len, input logic [7:0] pat, input bit en,
                      input string tag);
    logic [7:0] e;
    rst_n  = 1'b0;
    ena    = en;
    ui_in  = {2'b11, 5'(len), b};  // drive unused bits high to show they are ignored
    uio_in = pat;
    if (en) model_accept(b, len, pat, e);
    else e = {6'(m_cnt), m_sticky, 1'b0};
    exp_q.push_back(e);
    pop_and_check(tag);
  endtask

  // Reset with enable and data active to show reset has priority
  task automatic do_reset(input string tag);
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h03;
    uio_in = 8'h01;
    hist.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
    exp_q.push_back(8'h00);
    pop_and_check(tag);
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    m_cnt    = 0;
    m_sticky = 1'b0;
    do_reset("reset0");
    check("reset_state", uo_out, 8'h00);

    // Length 4, pattern 1011, pulses after bits 4 and 8
    begin
      bit seq[8] = '{1, 0, 1, 1, 1, 0, 1, 1};
      for (int i = 0; i < 8; i++) begin
        step(seq[i], 4, 8'h0B, 1'b1, $sformatf("l4_bit%0d", i));
        if (i == 3) check("l4_first_pulse", uo_out, 8'h07);
        if (i == 4) check("l4_no_pulse", uo_out, 8'h06);
      end
      check("l4_final", uo_out, 8'h0B);
    end

    // Length 1, overlapping matches on consecutive bits
    do_reset("reset1");
    for (int i = 0; i < 3; i++) step(1'b1, 1, 8'hFF, 1'b1, $sformatf("l1_bit%0d", i));
    check("l1_final", uo_out, 8'h0F);

    // Fill gating: zero pattern needs four received bits
    do_reset("reset2");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4, 8'hF0, 1'b1, $sformatf("fill_bit%0d", i));
      if (i == 2) check("fill_gate_3", uo_out, 8'h00);
    end
    check("fill_gate_4", uo_out, 8'h07);

    // Length 0 disables detection
    do_reset("reset3");
    for (int i = 0; i < 10; i++) step(1'($urandom), 0, 8'($urandom), 1'b1, "len0");
    check("len0_final", uo_out, 8'h00);

    // Mid-sequence reset discards history
    do_reset("reset4");
    step(1'b1, 4, 8'h0B, 1'b1, "mid_a");
    step(1'b0, 4, 8'h0B, 1'b1, "mid_b");
    step(1'b1, 4, 8'h0B, 1'b1, "mid_c");
    do_reset("reset5");
    step(1'b1, 4, 8'h0B, 1'b1, "mid_after");
    check("mid_no_match", uo_out, 8'h00);
    step(1'b1, 4, 8'h0B, 1'b1, "mid_full0");
    step(1'b0, 4, 8'h0B, 1'b1, "mid_full1");
    step(1'b1, 4, 8'h0B, 1'b1, "mid_full2");
    step(1'b1, 4, 8'h0B, 1'b1, "mid_full3");
    check("mid_full_match", uo_out, 8'h07);

    // Hold with enable low: pulse drops, state holds, toggling data is ignored
    step(1'b1, 4, 8'h0B, 1'b0, "hold0");
    check("hold_pulse_drop", uo_out, 8'h06);
    for (int i = 0; i < 4; i++) step(1'(i), 4, 8'h0B, 1'b0, "hold_toggle");
    step(1'b0, 4, 8'h0B, 1'b1, "hold_resume");
    check("hold_no_spurious", uo_out, 8'h06);

    // Changing length mid-stream keeps history: newest bits now 1,0
    step(1'b0, 2, 8'h02, 1'b1, "len_change");
    step(1'b1, 3, 8'h02, 1'b1, "len_change2");

    // Length above 8 clamps to 8
    do_reset("reset6");
    begin
      logic [7:0] p = 8'hA5;
      for (int i = 7; i >= 0; i--) step(p[i], 31, 8'hA5, 1'b1, "clamp");
    end
    check("clamp_match", uo_out, 8'h07);

    // Count saturates at 63
    do_reset("reset7");
    for (int i = 0; i < 70; i++) step(1'b1, 1, 8'h01, 1'b1, "sat");
    check("sat_final", uo_out, 8'hFF);

    // Random mix of data, lengths, patterns, enable and resets
    do_reset("reset8");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rand_reset");
      else step(1'($urandom), $urandom_range(0, 31), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                ($urandom_range(0, 4) != 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
